// File: rtl/mem_access_if.sv
// Bundles the request, data-memory and write-back signals of the memory-access
// stage. The master side is the environment (execute stage and data memory).
// The slave side is the mem_access block.
interface mem_access_if #(
  parameter int XLEN  = 32,
  parameter int RSLEN = 5
);
  // Request from execute
  logic             req_valid;
  logic             req_ready;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       size;
  logic             ld_unsigned;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic [RSLEN-1:0] rd_i;

  // Data-memory port
  logic             dmem_ce;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [3:0]       dmem_be;
  logic [XLEN-1:0]  dmem_wdata;
  logic [XLEN-1:0]  dmem_rdata;
  logic             dmem_ack;

  // Write-back and error reporting
  logic             wb_valid;
  logic [XLEN-1:0]  wb_data;
  logic [RSLEN-1:0] wb_rd;
  logic             err;

  modport master (
    output req_valid, mem_read, mem_write, size, ld_unsigned, addr, wdata, rd_i,
    output dmem_rdata, dmem_ack,
    input  req_ready, dmem_ce, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_data, wb_rd, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, size, ld_unsigned, addr, wdata, rd_i,
    input  dmem_rdata, dmem_ack,
    output req_ready, dmem_ce, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_data, wb_rd, err
  );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: accepts one request at a time from execute, checks size and
// alignment, drives a single word-aligned data-memory access with byte-lane
// enables, and returns the extended load result for write-back.
module mem_access #(
  parameter int XLEN  = 32,
  parameter int RSLEN = 5
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state;
  state_t state_nxt;

  logic req_ready;
  logic dmem_ce;
  logic start;
  logic reject;
  logic is_nop;
  logic illegal;

  // Latched request fields, stable for the whole access.
  logic             we_q;
  logic [XLEN-1:0]  addr_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [RSLEN-1:0] rd_q;
  logic [3:0]       be_q;
  logic [XLEN-1:0]  wdata_q;

  logic             err_q;
  logic             wb_valid_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [RSLEN-1:0] wb_rd_q;

  logic [3:0]       be_nxt;
  logic [XLEN-1:0]  wdata_nxt;
  logic [XLEN-1:0]  load_ext;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  // Request classification: neither direction is a no-op; conflicting
  // direction, size 11 or misalignment is rejected.
  assign is_nop  = !bus.mem_read && !bus.mem_write;
  assign illegal = (bus.mem_read && bus.mem_write)
                || (bus.size == 2'b11)
                || (bus.size == SZ_HALF && bus.addr[0])
                || (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, handshake and per-request decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt = state;
    req_ready = 1'b0;
    dmem_ce   = 1'b0;
    start     = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (bus.req_valid && req_ready && !is_nop) begin
          if (illegal) begin
            reject = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmem_ce = 1'b1;
        if (bus.dmem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-lane enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_nxt    = 4'b0000;
    wdata_nxt = bus.wdata;
    case (bus.size)
      SZ_BYTE: begin
        be_nxt    = 4'b0001 << bus.addr[1:0];
        wdata_nxt = {(XLEN/8){bus.wdata[7:0]}};
      end
      SZ_HALF: begin
        be_nxt    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {(XLEN/16){bus.wdata[15:0]}};
      end
      SZ_WORD: begin
        be_nxt    = 4'b1111;
        wdata_nxt = bus.wdata;
      end
      default: begin
        be_nxt    = 4'b0000;
        wdata_nxt = bus.wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned read word.
  always_comb begin
    lane_b   = bus.dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = bus.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    load_ext = bus.dmem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{(XLEN-8){lane_b[7] & ~uns_q}}, lane_b};
      SZ_HALF: load_ext = {{(XLEN-16){lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  // Request latch, error pulse and load write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      err_q      <= reject;
      wb_valid_q <= 1'b0;
      if (start) begin
        we_q    <= bus.mem_write;
        addr_q  <= {bus.addr[XLEN-1:2], 2'b00};
        off_q   <= bus.addr[1:0];
        size_q  <= bus.size;
        uns_q   <= bus.ld_unsigned;
        rd_q    <= bus.rd_i;
        be_q    <= be_nxt;
        wdata_q <= wdata_nxt;
      end
      // Only loads complete into write-back; stores finish silently.
      if (state == ACCESS && bus.dmem_ack && !we_q) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= load_ext;
        wb_rd_q    <= rd_q;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.dmem_ce    = dmem_ce;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a scoreboard of expected memory accesses
// and write-backs, a data-memory responder with per-access ack delay, and a
// negedge monitor comparing DUT outputs against the scoreboard.
module tb_mem_access;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_if #(.XLEN(32), .RSLEN(5)) bus ();

  mem_access #(.XLEN(32), .RSLEN(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } wb_t;

  acc_t acc_q[$];
  wb_t  wb_q[$];
  int   wb_times[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int ce_cnt   = 0;
  int wait_cnt = 0;
  logic        resp_en    = 1'b1;
  logic        acc_in_wb  = 1'b0;
  logic [31:0] last_addr  = 32'h0;
  logic [31:0] last_wb    = 32'h0;
  logic [4:0]  last_wb_rd = 5'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (off * 8);
    case (sz)
      2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Data-memory responder: acks the queued access after its programmed delay.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (bus.dmem_ce && acc_q.size() > 0) begin
          if (wait_cnt == acc_q[0].delay) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = acc_q[0].rdata;
            wait_cnt       = 0;
          end else begin
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = 32'h0BAD_F00D;
            wait_cnt++;
          end
        end else begin
          bus.dmem_ack   = 1'b0;
          bus.dmem_rdata = 32'h0BAD_F00D;
          wait_cnt       = 0;
        end
      end
    end
  end

  // Output monitor: compares memory accesses and write-backs with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ce_cnt = 0;
      end else begin
        if (bus.err) err_seen++;
        if (bus.dmem_ce) begin
          if (acc_q.size() == 0) begin
            check("ce_without_request", bus.dmem_ce, 1'b0);
          end else begin
            check("dmem_we",    bus.dmem_we,    acc_q[0].we);
            check("dmem_addr",  bus.dmem_addr,  acc_q[0].addr);
            check("dmem_be",    bus.dmem_be,    acc_q[0].be);
            check("dmem_wdata", bus.dmem_wdata, acc_q[0].wdata);
            ce_cnt++;
            if (bus.dmem_ack) begin
              check("ce_cycles", ce_cnt, acc_q[0].delay + 1);
              void'(acc_q.pop_front());
              ce_cnt = 0;
            end
          end
        end
        if (bus.wb_valid) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected", bus.wb_valid, 1'b0);
          end else begin
            wb_t w;
            w = wb_q.pop_front();
            check("wb_data",  bus.wb_data, w.data);
            check("wb_rd",    bus.wb_rd,   w.rd);
            check("wb_cycle", cyc,         w.cyc);
            wb_times.push_back(cyc);
            last_wb    = w.data;
            last_wb_rd = w.rd;
          end
        end
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                        input logic [31:0] rdata, input int delay);
    int   waited;
    logic nop;
    logic bad;
    acc_t ac;
    wb_t  w;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", bus.req_ready, 1'b1);
      return;
    end
    acc_in_wb = bus.wb_valid;
    nop = !rd && !wr;
    bad = !nop && ((rd && wr) || sz == 2'b11 || (sz == 2'b01 && a[0]) ||
                   (sz == 2'b10 && a[1:0] != 2'b00));
    bus.req_valid   = 1'b1;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.size        = sz;
    bus.ld_unsigned = uns;
    bus.addr        = a;
    bus.wdata       = wd;
    bus.rd_i        = rdi;
    if (!nop && !bad) begin
      ac.we    = wr;
      ac.addr  = {a[31:2], 2'b00};
      ac.be    = exp_be(sz, a[1:0]);
      ac.wdata = exp_wdata(sz, wd);
      ac.rdata = rdata;
      ac.delay = delay;
      acc_q.push_back(ac);
      last_addr = ac.addr;
      if (rd) begin
        w.data = exp_load(sz, uns, a[1:0], rdata);
        w.rd   = rdi;
        w.cyc  = cyc + delay + 2;
        wb_q.push_back(w);
      end
    end
    if (bad) err_exp++;
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.size        = 2'($urandom);
    bus.ld_unsigned = 1'($urandom);
    bus.addr        = $urandom;
    bus.wdata       = $urandom;
    bus.rd_i        = 5'($urandom);
    @(negedge clk);
    check("err_after_accept", bus.err, bad);
    if (nop || bad) begin
      check("ce_after_reject", bus.dmem_ce, 1'b0);
      check("addr_unchanged",  bus.dmem_addr, last_addr);
    end
    if (bad) begin
      @(negedge clk);
      check("err_one_cycle", bus.err, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((acc_q.size() + wb_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", acc_q.size() + wb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.size        = 2'b00;
    bus.ld_unsigned = 1'b0;
    bus.addr        = 32'h0;
    bus.wdata       = 32'h0;
    bus.rd_i        = 5'd0;
    bus.dmem_rdata  = 32'h0;
    bus.dmem_ack    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready",  bus.req_ready,  1'b0);
    check("rst_dmem_ce",    bus.dmem_ce,    1'b0);
    check("rst_dmem_we",    bus.dmem_we,    1'b0);
    check("rst_dmem_be",    bus.dmem_be,    4'b0000);
    check("rst_dmem_addr",  bus.dmem_addr,  32'h0);
    check("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
    check("rst_wb_valid",   bus.wb_valid,   1'b0);
    check("rst_wb_data",    bus.wb_data,    32'h0);
    check("rst_wb_rd",      bus.wb_rd,      5'd0);
    check("rst_err",        bus.err,        1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1'b1);

    // Word load, ack one cycle later
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 1);
    wait_idle();
    // Signed and unsigned byte loads from the top lane
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF_1234, 0);
    wait_idle();
    do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd8, 32'h80FF_1234, 0);
    wait_idle();
    // Half loads, signed upper half and unsigned lower half
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9,  32'h8001_7FFF, 2);
    wait_idle();
    do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd10, 32'h8001_7FFF, 0);
    wait_idle();
    // Half store with ack after 3 cycles; write-back registers must hold
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 5'd3, 32'h0, 3);
    wait_idle();
    check("wb_data_hold", bus.wb_data, last_wb);
    check("wb_rd_hold",   bus.wb_rd,   last_wb_rd);
    // Byte and word stores
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234_5678, 5'd0, 32'h0, 1);
    wait_idle();
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_BABE, 5'd0, 32'h0, 0);
    wait_idle();

    // Rejected requests and a no-op
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4, 32'h0, 0);
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 5'd4, 32'h0, 0);
    do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd4, 32'h0, 0);
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 5'd4, 32'h0, 0);
    do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h777, 32'h0, 5'd4, 32'h0, 0);

    // Back-to-back loads with immediate acks
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 5'd1, 32'h1111_2222, 0);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h702, 32'h0, 5'd2, 32'hF00F_3333, 0);
    check("accept_in_wb_cycle", acc_in_wb, 1'b1);
    wait_idle();
    if (wb_times.size() >= 2)
      check("b2b_wb_spacing", wb_times[wb_times.size()-1] - wb_times[wb_times.size()-2], 2);
    else
      check("b2b_wb_count", wb_times.size(), 2);

    // Reset during an access, then a late ack while idle
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd6, 32'h5555_AAAA, 1000);
    @(negedge clk);
    check("ce_before_abort", bus.dmem_ce, 1'b1);
    resp_en = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("abort_ce",       bus.dmem_ce,   1'b0);
    check("abort_ready",    bus.req_ready, 1'b0);
    check("abort_wb_valid", bus.wb_valid,  1'b0);
    check("abort_be",       bus.dmem_be,   4'b0000);
    acc_q.delete();
    wb_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("late_ack_ce",    bus.dmem_ce,   1'b0);
    check("late_ack_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_wb_valid", bus.wb_valid, 1'b0);
    resp_en = 1'b1;

    // Normal operation after the abort
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd11, 32'h1357_9BDF, 2);
    wait_idle();
    repeat (2) @(negedge clk);
    check("err_count", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
